// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter round-robin readout scheduler.
package counter_sched_pkg;

   localparam int unsigned DEF_NUM_SOURCES = 3;
   localparam int unsigned DEF_WIDTH       = 32;
   localparam int unsigned DEF_DROP_W      = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } sched_state_t;

   typedef logic [DEF_NUM_SOURCES-1:0][DEF_WIDTH-1:0] counter_bank_t;

   // Index width for a source count; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/counter_rr_sched_if.sv
// Snapshot output port: valid/ready handshake carrying index, data and parity.
interface counter_rr_sched_if
   import counter_sched_pkg::*;
#(
   parameter int unsigned NUM_SOURCES = DEF_NUM_SOURCES,
   parameter int unsigned WIDTH       = DEF_WIDTH
) ();

   localparam int unsigned IDX_W = idx_width(NUM_SOURCES);

   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic [WIDTH-1:0] out_data;
   logic             out_parity;

   modport master (
      output out_valid,
      output out_idx,
      output out_data,
      output out_parity,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_idx,
      input  out_data,
      input  out_parity,
      output out_ready
   );

endinterface

// File: rtl/counter_rr_sched_rr_pick.sv
// Rotating-priority picker: first set bit of eff at or above ptr, wrapping to 0.
module rr_pick #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     eff,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   int unsigned cand;

   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      cand   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= N) cand = cand - N;
         if (!any && eff[IDX_W'(cand)]) begin
            any                  = 1'b1;
            idx                  = IDX_W'(cand);
            onehot[IDX_W'(cand)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_rr_sched.sv
// Round-robin readout scheduler: grants one flagged counter per transaction and
// presents a registered snapshot (index, value, parity) on a valid/ready port.
module counter_rr_sched
   import counter_sched_pkg::*;
#(
   parameter int unsigned NUM_SOURCES = DEF_NUM_SOURCES,
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned DROP_W      = DEF_DROP_W
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_SOURCES-1:0]                req,
   input  logic [NUM_SOURCES-1:0][WIDTH-1:0]     counter,
   output logic [NUM_SOURCES-1:0]                gnt,
   counter_rr_sched_if.master                    snap,
   output logic                                  busy,
   output logic [DROP_W-1:0]                     drop_cnt
);

   localparam int unsigned IDX_W = idx_width(NUM_SOURCES);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   sched_state_t           state;
   logic [NUM_SOURCES-1:0] pending_q;
   logic [IDX_W-1:0]       ptr;

   logic [NUM_SOURCES-1:0] eff;
   logic [NUM_SOURCES-1:0] pick_onehot;
   logic [NUM_SOURCES-1:0] grant_vec;
   logic [NUM_SOURCES-1:0] pending_d;
   logic [NUM_SOURCES-1:0] coalesced;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       ptr_nxt;
   logic                   pick_any;
   logic                   grant;
   logic                   busy_d;
   logic [DROP_W-1:0]      drop_nxt;
   int unsigned            add_cnt;
   int unsigned            headroom;

   rr_pick #(
      .N     (NUM_SOURCES),
      .IDX_W (IDX_W)
   ) u_pick (
      .eff    (eff),
      .ptr    (ptr),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   // A new grant is allowed when idle or when the current snapshot is being taken.
   always_comb begin
      eff       = pending_q | req;
      grant     = pick_any && ((state == IDLE) || snap.out_ready);
      grant_vec = grant ? pick_onehot : '0;
      pending_d = eff & ~grant_vec;
      coalesced = req & pending_q & ~grant_vec;
      ptr_nxt   = (32'(pick_idx) == NUM_SOURCES - 1) ? '0 : pick_idx + IDX_W'(1);
      busy_d    = grant || ((state == SEND) && !snap.out_ready) || (|pending_d);
   end

   // Saturating add of this cycle's coalesced-request popcount.
   always_comb begin
      add_cnt = 0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) add_cnt += 32'(coalesced[i]);
      headroom = 32'(DROP_MAX - drop_cnt);
      if (add_cnt > headroom) drop_nxt = DROP_MAX;
      else                    drop_nxt = drop_cnt + DROP_W'(add_cnt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         pending_q       <= '0;
         ptr             <= '0;
         gnt             <= '0;
         busy            <= 1'b0;
         drop_cnt        <= '0;
         snap.out_valid  <= 1'b0;
         snap.out_idx    <= '0;
         snap.out_data   <= '0;
         snap.out_parity <= 1'b0;
      end else begin
         pending_q <= pending_d;
         gnt       <= grant_vec;
         busy      <= busy_d;
         drop_cnt  <= drop_nxt;
         if (grant) begin
            state           <= SEND;
            ptr             <= ptr_nxt;
            snap.out_valid  <= 1'b1;
            snap.out_idx    <= pick_idx;
            snap.out_data   <= counter[pick_idx];
            snap.out_parity <= ^counter[pick_idx];
         end else if ((state == SEND) && snap.out_ready) begin
            state          <= IDLE;
            snap.out_valid <= 1'b0;
         end
      end
   end

endmodule
